// File: rtl/rvfi_chk_pkg.sv
// Shared types for the RVFI PC-continuity checker: error codes, sync state,
// and the reorder-window entry layout.
`timescale 1ns/1ps
package rvfi_chk_pkg;

  localparam int ORDER_W  = 64;
  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ERR_NONE        = 2'd0,
    ERR_PC_MISMATCH = 2'd1,
    ERR_DUP_ORDER   = 2'd2,
    ERR_OVERFLOW    = 2'd3
  } err_kind_t;

  typedef enum logic {
    ST_UNSYNCED = 1'b0,
    ST_SYNCED   = 1'b1
  } sync_state_t;

  // Default-width entry; the window redeclares this layout at its own XLEN.
  typedef struct packed {
    logic                valid;
    logic [ORDER_W-1:0]  order;
    logic [XLEN_DEF-1:0] pc_rdata;
    logic [XLEN_DEF-1:0] pc_wdata;
  } win_entry_t;

endpackage

// File: rtl/rvfi_order_win.sv
// Reorder window: DEPTH buffered retirements, lowest-free-slot allocation in
// channel order, per-channel order lookup, and consume-by-mask release.
`timescale 1ns/1ps
module rvfi_order_win
  import rvfi_chk_pkg::*;
#(
  parameter int NRET   = 2,
  parameter int XLEN   = 32,
  parameter int DEPTH  = 8,
  parameter int PEND_W = $clog2(DEPTH + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [DEPTH-1:0]          i_consume,
  input  logic [NRET-1:0]           i_ins_valid,
  input  logic [ORDER_W*NRET-1:0]   i_ins_order,
  input  logic [XLEN*NRET-1:0]      i_ins_rdata,
  input  logic [XLEN*NRET-1:0]      i_ins_wdata,
  input  logic [ORDER_W*NRET-1:0]   i_query_order,
  output logic [NRET-1:0]           o_query_hit,
  output logic [NRET-1:0]           o_ins_drop,
  output logic [DEPTH-1:0]          o_valid,
  output logic [ORDER_W*DEPTH-1:0]  o_order,
  output logic [XLEN*DEPTH-1:0]     o_rdata,
  output logic [XLEN*DEPTH-1:0]     o_wdata,
  output logic [PEND_W-1:0]         o_pending
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic               valid;
    logic [ORDER_W-1:0] order;
    logic [XLEN-1:0]    pc_rdata;
    logic [XLEN-1:0]    pc_wdata;
  } entry_t;

  entry_t           r_win [DEPTH];
  logic [NRET-1:0]  w_alloc_ok;
  logic [IDX_W-1:0] w_alloc_idx [NRET];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_rd
      assign o_valid[gi]                      = r_win[gi].valid;
      assign o_order[ORDER_W*gi +: ORDER_W]   = r_win[gi].order;
      assign o_rdata[XLEN*gi +: XLEN]         = r_win[gi].pc_rdata;
      assign o_wdata[XLEN*gi +: XLEN]         = r_win[gi].pc_wdata;
    end
  endgenerate

  always_comb begin : query
    o_query_hit = '0;
    for (int c = 0; c < NRET; c++)
      for (int d = 0; d < DEPTH; d++)
        if (r_win[d].valid && r_win[d].order == i_query_order[ORDER_W*c +: ORDER_W])
          o_query_hit[c] = 1'b1;
  end

  // Slots freed by this cycle's consume are not offered until next cycle.
  always_comb begin : alloc
    logic [DEPTH-1:0] free;
    free       = ~o_valid;
    w_alloc_ok = '0;
    o_ins_drop = '0;
    for (int c = 0; c < NRET; c++) begin
      w_alloc_idx[c] = '0;
      if (i_ins_valid[c]) begin
        for (int d = 0; d < DEPTH; d++) begin
          if (!w_alloc_ok[c] && free[d]) begin
            w_alloc_ok[c]  = 1'b1;
            w_alloc_idx[c] = IDX_W'(d);
            free[d]        = 1'b0;
          end
        end
        o_ins_drop[c] = !w_alloc_ok[c];
      end
    end
  end

  always_comb begin : count
    o_pending = '0;
    for (int d = 0; d < DEPTH; d++)
      o_pending = o_pending + PEND_W'(r_win[d].valid);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int d = 0; d < DEPTH; d++) r_win[d] <= '0;
    end else begin
      for (int d = 0; d < DEPTH; d++)
        if (i_consume[d]) r_win[d].valid <= 1'b0;
      for (int c = 0; c < NRET; c++)
        if (w_alloc_ok[c])
          r_win[w_alloc_idx[c]] <= entry_t'{1'b1,
                                            i_ins_order[ORDER_W*c +: ORDER_W],
                                            i_ins_rdata[XLEN*c +: XLEN],
                                            i_ins_wdata[XLEN*c +: XLEN]};
    end
  end

endmodule

// File: rtl/rvfi_pc_chain_check.sv
// In-order PC-continuity checker for an NRET-channel RVFI stream: baseline
// sync, unrolled chain walk over window + incoming, sticky first-error latch.
`timescale 1ns/1ps
module rvfi_pc_chain_check
  import rvfi_chk_pkg::*;
#(
  parameter int NRET    = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int CMP_LSB = 1,
  parameter int CNT_W   = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         check,
  input  logic [NRET-1:0]              rvfi_valid,
  input  logic [64*NRET-1:0]           rvfi_order,
  input  logic [XLEN*NRET-1:0]         rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]         rvfi_pc_wdata,
  output logic                         synced,
  output logic                         err,
  output logic [1:0]                   err_kind,
  output logic [63:0]                  err_order,
  output logic [CNT_W-1:0]             checked_cnt,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int NCAND  = DEPTH + NRET;
  localparam int PEND_W = $clog2(DEPTH + 1);
  localparam int STEP_W = $clog2(NCAND + 2);

  sync_state_t        r_state;
  logic [63:0]        r_next_order;
  logic [XLEN-1:0]    r_expected_pc;
  logic               r_err;
  err_kind_t          r_err_kind;
  logic [63:0]        r_err_order;
  logic [CNT_W-1:0]   r_checked_cnt;

  logic [DEPTH-1:0]         w_win_valid;
  logic [64*DEPTH-1:0]      w_win_order;
  logic [XLEN*DEPTH-1:0]    w_win_rdata, w_win_wdata;
  logic [PEND_W-1:0]        w_win_pending;
  logic [NRET-1:0]          w_query_hit, w_ins_drop;

  logic [NRET-1:0]  w_base_sel, w_elig, w_dup, w_keep;
  logic             w_base_hit, w_first;
  logic [63:0]      w_base_order, w_start_order, w_end_order;
  logic [XLEN-1:0]  w_base_wdata, w_start_pc, w_end_pc;

  logic [NCAND-1:0] w_cand_valid, w_cons;
  logic [63:0]      w_cand_order [NCAND];
  logic [XLEN-1:0]  w_cand_rd [NCAND];
  logic [XLEN-1:0]  w_cand_wd [NCAND];
  logic [STEP_W-1:0] w_steps;
  logic             w_mm_hit, w_dup_hit, w_ovf_hit;
  logic [63:0]      w_mm_order, w_dup_order, w_ovf_order;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;

  always_comb begin : baseline
    w_base_hit   = 1'b0;
    w_base_sel   = '0;
    w_base_order = '0;
    w_base_wdata = '0;
    for (int c = 0; c < NRET; c++) begin
      if (rvfi_valid[c] && (!w_base_hit || rvfi_order[64*c +: 64] < w_base_order)) begin
        w_base_hit    = 1'b1;
        w_base_sel    = '0;
        w_base_sel[c] = 1'b1;
        w_base_order  = rvfi_order[64*c +: 64];
        w_base_wdata  = rvfi_pc_wdata[XLEN*c +: XLEN];
      end
    end
    w_first       = (r_state == ST_UNSYNCED) && w_base_hit;
    w_start_order = w_first ? w_base_order + 64'd1 : r_next_order;
    w_start_pc    = w_first ? w_base_wdata : r_expected_pc;
  end

  // A later channel repeating an earlier channel's order is the one dropped.
  always_comb begin : filter
    w_elig = '0;
    w_dup  = '0;
    for (int c = 0; c < NRET; c++)
      w_elig[c] = rvfi_valid[c] && (r_state == ST_SYNCED || w_first)
                  && !(w_first && w_base_sel[c]);
    for (int c = 0; c < NRET; c++) begin
      if (w_elig[c]) begin
        if (rvfi_order[64*c +: 64] < w_start_order || w_query_hit[c]) w_dup[c] = 1'b1;
        for (int j = 0; j < NRET; j++)
          if (j < c && w_elig[j] && rvfi_order[64*j +: 64] == rvfi_order[64*c +: 64])
            w_dup[c] = 1'b1;
      end
    end
    w_keep = w_elig & ~w_dup;
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_cand_win
      assign w_cand_valid[gi] = w_win_valid[gi];
      assign w_cand_order[gi] = w_win_order[64*gi +: 64];
      assign w_cand_rd[gi]    = w_win_rdata[XLEN*gi +: XLEN];
      assign w_cand_wd[gi]    = w_win_wdata[XLEN*gi +: XLEN];
    end
    for (gi = 0; gi < NRET; gi++) begin : g_cand_in
      assign w_cand_valid[DEPTH+gi] = w_keep[gi];
      assign w_cand_order[DEPTH+gi] = rvfi_order[64*gi +: 64];
      assign w_cand_rd[DEPTH+gi]    = rvfi_pc_rdata[XLEN*gi +: XLEN];
      assign w_cand_wd[DEPTH+gi]    = rvfi_pc_wdata[XLEN*gi +: XLEN];
    end
  endgenerate

  // Orders among candidates are unique, so each step matches at most one.
  always_comb begin : walk
    logic            going, hit;
    logic [XLEN-1:0] step_rd, step_wd;
    w_cons      = '0;
    w_steps     = '0;
    w_mm_hit    = 1'b0;
    w_mm_order  = '0;
    w_end_order = w_start_order;
    w_end_pc    = w_start_pc;
    going       = 1'b1;
    for (int s = 0; s < NCAND; s++) begin
      hit     = 1'b0;
      step_rd = '0;
      step_wd = '0;
      for (int k = 0; k < NCAND; k++) begin
        if (going && w_cand_valid[k] && w_cand_order[k] == w_end_order) begin
          hit       = 1'b1;
          step_rd   = step_rd | w_cand_rd[k];
          step_wd   = step_wd | w_cand_wd[k];
          w_cons[k] = 1'b1;
        end
      end
      if (hit) begin
        if (!w_mm_hit && (((step_rd ^ w_end_pc) >> CMP_LSB) != '0)) begin
          w_mm_hit   = 1'b1;
          w_mm_order = w_end_order;
        end
        w_end_pc    = step_wd;
        w_end_order = w_end_order + 64'd1;
        w_steps     = w_steps + STEP_W'(1);
      end else begin
        going = 1'b0;
      end
    end
  end

  always_comb begin : err_pick
    w_dup_hit   = 1'b0;
    w_dup_order = '0;
    w_ovf_hit   = 1'b0;
    w_ovf_order = '0;
    for (int c = 0; c < NRET; c++) begin
      if (w_dup[c] && !w_dup_hit) begin
        w_dup_hit   = 1'b1;
        w_dup_order = rvfi_order[64*c +: 64];
      end
      if (w_ins_drop[c] && !w_ovf_hit) begin
        w_ovf_hit   = 1'b1;
        w_ovf_order = rvfi_order[64*c +: 64];
      end
    end
  end

  assign w_cnt_sum  = {1'b0, r_checked_cnt} + (CNT_W+1)'(w_steps) + (CNT_W+1)'(w_first);
  assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

  rvfi_order_win #(
    .NRET   (NRET),
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .PEND_W (PEND_W)
  ) u_win (
    .clock         (clock),
    .reset         (reset),
    .i_consume     (w_cons[DEPTH-1:0]),
    .i_ins_valid   (w_keep & ~w_cons[NCAND-1:DEPTH]),
    .i_ins_order   (rvfi_order),
    .i_ins_rdata   (rvfi_pc_rdata),
    .i_ins_wdata   (rvfi_pc_wdata),
    .i_query_order (rvfi_order),
    .o_query_hit   (w_query_hit),
    .o_ins_drop    (w_ins_drop),
    .o_valid       (w_win_valid),
    .o_order       (w_win_order),
    .o_rdata       (w_win_rdata),
    .o_wdata       (w_win_wdata),
    .o_pending     (w_win_pending)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_UNSYNCED;
      r_next_order  <= '0;
      r_expected_pc <= '0;
      r_err         <= 1'b0;
      r_err_kind    <= ERR_NONE;
      r_err_order   <= '0;
      r_checked_cnt <= '0;
    end else begin
      if (w_first) r_state <= ST_SYNCED;
      r_next_order  <= w_end_order;
      r_expected_pc <= w_end_pc;
      r_checked_cnt <= w_cnt_next;
      if (check && !r_err) begin
        if (w_mm_hit) begin
          r_err       <= 1'b1;
          r_err_kind  <= ERR_PC_MISMATCH;
          r_err_order <= w_mm_order;
        end else if (w_dup_hit) begin
          r_err       <= 1'b1;
          r_err_kind  <= ERR_DUP_ORDER;
          r_err_order <= w_dup_order;
        end else if (w_ovf_hit) begin
          r_err       <= 1'b1;
          r_err_kind  <= ERR_OVERFLOW;
          r_err_order <= w_ovf_order;
        end
      end
    end
  end

  assign synced      = (r_state == ST_SYNCED);
  assign err         = r_err;
  assign err_kind    = r_err_kind;
  assign err_order   = r_err_order;
  assign checked_cnt = r_checked_cnt;
  assign pending     = w_win_pending;

`ifdef FORMAL
  always_ff @(posedge clock) begin
    if (!reset && check) assert (!r_err);
  end
`endif

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
// Directed bench: u_a uses defaults (CMP_LSB=1, DEPTH=8), u_b uses CMP_LSB=2,
// DEPTH=2; both see the same stimulus and are reset between scenarios.
`timescale 1ns/1ps
module tb_rvfi_pc_chain_check;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         check = 1'b1;
  logic [1:0]   rvfi_valid = '0;
  logic [127:0] rvfi_order = '0;
  logic [63:0]  rvfi_pc_rdata = '0;
  logic [63:0]  rvfi_pc_wdata = '0;

  logic        a_synced, a_err, b_synced, b_err;
  logic [1:0]  a_kind, b_kind;
  logic [63:0] a_order, b_order;
  logic [31:0] a_cnt, b_cnt;
  logic [3:0]  a_pend;
  logic [1:0]  b_pend;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  rvfi_pc_chain_check u_a (
    .clock(clock), .reset(reset), .check(check),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .synced(a_synced), .err(a_err), .err_kind(a_kind), .err_order(a_order),
    .checked_cnt(a_cnt), .pending(a_pend)
  );

  rvfi_pc_chain_check #(.CMP_LSB(2), .DEPTH(2)) u_b (
    .clock(clock), .reset(reset), .check(check),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .synced(b_synced), .err(b_err), .err_kind(b_kind), .err_order(b_order),
    .checked_cnt(b_cnt), .pending(b_pend)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [1:0] v,
                      input logic [63:0] o0, input logic [31:0] r0, input logic [31:0] w0,
                      input logic [63:0] o1, input logic [31:0] r1, input logic [31:0] w1);
    rvfi_valid    = v;
    rvfi_order    = {o1, o0};
    rvfi_pc_rdata = {r1, r0};
    rvfi_pc_wdata = {w1, w0};
    @(posedge clock);
    #1;
    rvfi_valid = '0;
    $display("step t=%0t rst=%0b chk=%0b valid=%b ch0=%0d/%0h->%0h ch1=%0d/%0h->%0h | a:err=%0b k=%0d o=%0d cnt=%0d pend=%0d b:err=%0b k=%0d o=%0d pend=%0d",
             $time, reset, check, v, o0, r0, w0, o1, r1, w1,
             a_err, a_kind, a_order, a_cnt, a_pend, b_err, b_kind, b_order, b_pend);
  endtask

  task automatic one(input logic [63:0] o, input logic [31:0] r, input logic [31:0] w);
    step(2'b01, o, r, w, 64'd0, 32'd0, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2'b00, 64'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    // Power-on reset
    reset = 1'b1;
    step(2'b00, 64'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
    step(2'b00, 64'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
    reset = 1'b0;
    chk("rst_synced", 64'(a_synced), 64'd0);
    chk("rst_err",    64'(a_err),    64'd0);
    chk("rst_kind",   64'(a_kind),   64'd0);
    chk("rst_order",  a_order,       64'd0);
    chk("rst_cnt",    64'(a_cnt),    64'd0);
    chk("rst_pend",   64'(a_pend),   64'd0);

    // In-order pair then a single
    step(2'b11, 64'd10, 32'h100, 32'h104, 64'd11, 32'h104, 32'h108);
    one(64'd12, 32'h108, 32'h10C);
    chk("inord_synced", 64'(a_synced), 64'd1);
    chk("inord_err",    64'(a_err),    64'd0);
    chk("inord_cnt",    64'(a_cnt),    64'd3);
    chk("inord_pend",   64'(a_pend),   64'd0);
    chk("inord_cnt_b",  64'(b_cnt),    64'd3);

    // Out-of-order across cycles
    do_reset();
    one(64'd19, 32'h1FC, 32'h200);
    one(64'd21, 32'h204, 32'h208);
    chk("ooo_pend1", 64'(a_pend), 64'd1);
    chk("ooo_err1",  64'(a_err),  64'd0);
    chk("ooo_cnt1",  64'(a_cnt),  64'd1);
    one(64'd20, 32'h200, 32'h204);
    chk("ooo_pend2", 64'(a_pend), 64'd0);
    chk("ooo_cnt2",  64'(a_cnt),  64'd3);
    chk("ooo_err2",  64'(a_err),  64'd0);

    // PC mismatch, first error latched
    do_reset();
    one(64'd5, 32'h3C, 32'h40);
    one(64'd6, 32'h44, 32'h48);
    chk("mm_err",    64'(a_err),  64'd1);
    chk("mm_kind",   64'(a_kind), 64'd1);
    chk("mm_order",  a_order,     64'd6);
    chk("mm_cnt",    64'(a_cnt),  64'd2);
    chk("mm_kind_b", 64'(b_kind), 64'd1);
    one(64'd7, 32'h99, 32'h9C);
    chk("mm_kind_keep",  64'(a_kind), 64'd1);
    chk("mm_order_keep", a_order,     64'd6);

    // Masked low PC bits
    do_reset();
    one(64'd0, 32'h0, 32'h80);
    one(64'd1, 32'h81, 32'h84);
    chk("lsb1_err_a", 64'(a_err), 64'd0);
    chk("lsb1_err_b", 64'(b_err), 64'd0);
    one(64'd2, 32'h86, 32'h88);
    chk("lsb2_kind_a",  64'(a_kind), 64'd1);
    chk("lsb2_order_a", a_order,     64'd2);
    chk("lsb2_err_b",   64'(b_err),  64'd0);
    one(64'd3, 32'h8C, 32'h90);
    chk("lsb3_kind_b",  64'(b_kind), 64'd1);
    chk("lsb3_order_b", b_order,     64'd3);
    chk("lsb3_order_a", a_order,     64'd2);

    // check=0 masks errors; repeated order after consumption
    do_reset();
    one(64'd5, 32'h0, 32'h10);
    check = 1'b0;
    one(64'd6, 32'h99, 32'h14);
    chk("nochk_err", 64'(a_err), 64'd0);
    chk("nochk_cnt", 64'(a_cnt), 64'd2);
    check = 1'b1;
    one(64'd7, 32'h14, 32'h18);
    chk("dup_pre_err", 64'(a_err), 64'd0);
    one(64'd7, 32'h14, 32'h18);
    chk("dup_err",   64'(a_err),  64'd1);
    chk("dup_kind",  64'(a_kind), 64'd2);
    chk("dup_order", a_order,     64'd7);
    chk("dup_cnt",   64'(a_cnt),  64'd3);

    // Overflow on the 2-entry window with a hole at order 1
    do_reset();
    one(64'd0, 32'h0, 32'h4);
    step(2'b11, 64'd2, 32'h10, 32'h14, 64'd3, 32'h14, 32'h18);
    chk("ovf_pend_b0", 64'(b_pend), 64'd2);
    chk("ovf_err_b0",  64'(b_err),  64'd0);
    one(64'd4, 32'h18, 32'h1C);
    chk("ovf_err_b",   64'(b_err),  64'd1);
    chk("ovf_kind_b",  64'(b_kind), 64'd3);
    chk("ovf_order_b", b_order,     64'd4);
    chk("ovf_pend_b",  64'(b_pend), 64'd2);
    chk("ovf_pend_a",  64'(a_pend), 64'd3);
    chk("ovf_err_a",   64'(a_err),  64'd0);

    // Reset mid-run with traffic on the reset cycle
    reset = 1'b1;
    step(2'b11, 64'd50, 32'h0, 32'h0, 64'd51, 32'h0, 32'h0);
    reset = 1'b0;
    chk("mrst_synced_b", 64'(b_synced), 64'd0);
    chk("mrst_err_b",    64'(b_err),    64'd0);
    chk("mrst_kind_b",   64'(b_kind),   64'd0);
    chk("mrst_order_b",  b_order,       64'd0);
    chk("mrst_cnt_b",    64'(b_cnt),    64'd0);
    chk("mrst_pend_b",   64'(b_pend),   64'd0);
    chk("mrst_synced_a", 64'(a_synced), 64'd0);

    // New baseline from the lower order on ch1; ch0 continues from it
    step(2'b11, 64'd101, 32'h500, 32'h504, 64'd100, 32'h4FC, 32'h500);
    chk("rebase_synced_b", 64'(b_synced), 64'd1);
    chk("rebase_cnt_b",    64'(b_cnt),    64'd2);
    chk("rebase_err_b",    64'(b_err),    64'd0);
    chk("rebase_pend_b",   64'(b_pend),   64'd0);
    chk("rebase_cnt_a",    64'(a_cnt),    64'd2);

    // Same order on both channels in one cycle: ch1 is the duplicate
    step(2'b11, 64'd102, 32'h504, 32'h508, 64'd102, 32'h504, 32'h508);
    chk("samedup_err",   64'(a_err),  64'd1);
    chk("samedup_kind",  64'(a_kind), 64'd2);
    chk("samedup_order", a_order,     64'd102);
    chk("samedup_cnt",   64'(a_cnt),  64'd3);
    chk("samedup_pend",  64'(a_pend), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
